// File: rtl/serial_in_parallel_out_framed_receiver_pkg.sv
// Shared types and helpers for the framed serial-to-parallel receiver.
package serial_in_parallel_out_framed_receiver_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_in_parallel_out_framed_receiver_if.sv
// Serial input, framing control and Valid/Ack output bundle of the receiver.
interface serial_in_parallel_out_framed_receiver_if
  import serial_in_parallel_out_framed_receiver_pkg::*;
#(
  parameter int WIDTH = 4
);
  localparam int CW = cnt_width(WIDTH);

  logic             shift_in;
  logic             shift_en;
  logic             sync;
  logic             ack;
  logic [WIDTH-1:0] parallel_out;
  logic             valid;
  logic             overrun;
  logic [CW-1:0]    bit_count;
  logic [WIDTH-1:0] reg_content;

  modport master (
    output shift_in, shift_en, sync, ack,
    input  parallel_out, valid, overrun, bit_count, reg_content
  );

  modport slave (
    input  shift_in, shift_en, sync, ack,
    output parallel_out, valid, overrun, bit_count, reg_content
  );

endinterface

// File: rtl/serial_in_parallel_out_framed_receiver_shift_core.sv
// Shift register and frame bit counter; flags the cycle a word completes.
module sipo_shift_core
  import serial_in_parallel_out_framed_receiver_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int CW = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_in,
  input  logic             shift_en,
  input  logic             sync,
  output logic [WIDTH-1:0] shift_reg,
  output logic [CW-1:0]    bit_count,
  output logic             word_done,
  output logic [WIDTH-1:0] next_word
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  assign next_word = {shift_reg[WIDTH-2:0], shift_in};
  // A Sync on the final-bit cycle restarts the frame instead of completing it.
  assign word_done = shift_en && !sync && (bit_count == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg <= '0;
      bit_count <= '0;
    end else if (shift_en) begin
      shift_reg <= next_word;
      if (sync)
        bit_count <= CW'(1);
      else if (word_done)
        bit_count <= '0;
      else
        bit_count <= bit_count + CW'(1);
    end else if (sync) begin
      bit_count <= '0;
    end
  end

endmodule

// File: rtl/serial_in_parallel_out_framed_receiver.sv
// Framed serial receiver: shift core plus a one-word Valid/Ack output buffer.
module serial_in_parallel_out_framed_receiver
  import serial_in_parallel_out_framed_receiver_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic clk,
  input logic reset,
  serial_in_parallel_out_framed_receiver_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  buf_state_t       state;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    bit_count;
  logic             word_done;
  logic [WIDTH-1:0] next_word;
  logic [WIDTH-1:0] parallel_out;
  logic             overrun;

  sipo_shift_core #(.WIDTH(WIDTH)) core (
    .clk       (clk),
    .reset     (reset),
    .shift_in  (bus.shift_in),
    .shift_en  (bus.shift_en),
    .sync      (bus.sync),
    .shift_reg (shift_reg),
    .bit_count (bit_count),
    .word_done (word_done),
    .next_word (next_word)
  );

  // A word landing on a full, unacknowledged buffer is dropped and flagged.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= EMPTY;
      parallel_out <= '0;
      overrun      <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (word_done) begin
            parallel_out <= next_word;
            state        <= FULL;
          end
        end
        FULL: begin
          if (word_done) begin
            if (bus.ack)
              parallel_out <= next_word;
            else
              overrun <= 1'b1;
          end else if (bus.ack) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign bus.parallel_out = parallel_out;
  assign bus.valid        = (state == FULL);
  assign bus.overrun      = overrun;
  assign bus.bit_count    = bit_count;
  assign bus.reg_content  = shift_reg;

endmodule

// File: tb/tb_serial_in_parallel_out_framed_receiver.sv
// Directed bench for the framed serial receiver at WIDTH=4.
module tb_serial_in_parallel_out_framed_receiver;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   passed = 0;

  serial_in_parallel_out_framed_receiver_if #(.WIDTH(4)) bus ();

  serial_in_parallel_out_framed_receiver #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Drive one clock's worth of inputs at negedge, return just after the posedge.
  task automatic applyStimulus(input logic en, input logic b, input logic s, input logic a);
    @(negedge clk);
    bus.shift_en = en;
    bus.shift_in = b;
    bus.sync     = s;
    bus.ack      = a;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic sendWord(input logic [3:0] w, input logic a);
    for (int i = 3; i >= 0; i--)
      applyStimulus(1'b1, w[i], 1'b0, a);
  endtask

  initial begin
    bus.shift_en = 1'b0;
    bus.shift_in = 1'b0;
    bus.sync     = 1'b0;
    bus.ack      = 1'b0;
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    reset = 1'b0;

    $display("[TB] random traffic then reset");
    for (int i = 0; i < 11; i++)
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_parallel_out", bus.parallel_out, 0);
    checkOutput("rst_valid", bus.valid, 0);
    checkOutput("rst_overrun", bus.overrun, 0);
    checkOutput("rst_bit_count", bus.bit_count, 0);
    checkOutput("rst_reg_content", bus.reg_content, 0);
    reset = 1'b0;

    $display("[TB] loopback 1011");
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("loop_valid_early", bus.valid, 0);
    checkOutput("loop_bit_count_3", bus.bit_count, 3);
    applyStimulus(1, 1, 0, 0);
    checkOutput("loop_parallel_out", bus.parallel_out, 4'b1011);
    checkOutput("loop_valid", bus.valid, 1);
    checkOutput("loop_bit_count_wrap", bus.bit_count, 0);
    checkOutput("loop_reg_content", bus.reg_content, 4'b1011);
    applyStimulus(0, 0, 0, 1);
    checkOutput("loop_ack_valid", bus.valid, 0);
    checkOutput("loop_ack_hold", bus.parallel_out, 4'b1011);

    $display("[TB] gapped 0110");
    applyStimulus(1, 0, 0, 0);
    checkOutput("gap_bc1", bus.bit_count, 1);
    applyStimulus(0, 1, 0, 0);
    checkOutput("gap_bc1_idle", bus.bit_count, 1);
    applyStimulus(1, 1, 0, 0);
    checkOutput("gap_bc2", bus.bit_count, 2);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("gap_bc3", bus.bit_count, 3);
    applyStimulus(0, 1, 0, 0);
    checkOutput("gap_valid_idle", bus.valid, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("gap_bc0", bus.bit_count, 0);
    checkOutput("gap_parallel_out", bus.parallel_out, 4'b0110);
    checkOutput("gap_valid", bus.valid, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("gap_ack_valid", bus.valid, 0);

    $display("[TB] overrun");
    sendWord(4'b1100, 1'b0);
    checkOutput("ovr_first_word", bus.parallel_out, 4'b1100);
    checkOutput("ovr_not_yet", bus.overrun, 0);
    sendWord(4'b0011, 1'b0);
    checkOutput("ovr_held_word", bus.parallel_out, 4'b1100);
    checkOutput("ovr_flag", bus.overrun, 1);
    checkOutput("ovr_valid", bus.valid, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("ovr_ack_valid", bus.valid, 0);
    checkOutput("ovr_sticky", bus.overrun, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("ovr_sticky_later", bus.overrun, 1);

    reset = 1'b1;
    applyStimulus(0, 0, 0, 0);
    reset = 1'b0;
    checkOutput("rst_clears_overrun", bus.overrun, 0);

    $display("[TB] simultaneous ack and completion");
    sendWord(4'b1001, 1'b0);
    checkOutput("sim_first", bus.parallel_out, 4'b1001);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 0, 1);
    checkOutput("sim_parallel_out", bus.parallel_out, 4'b0101);
    checkOutput("sim_valid", bus.valid, 1);
    checkOutput("sim_overrun", bus.overrun, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("sim_ack_valid", bus.valid, 0);

    $display("[TB] sync mid-frame");
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("sync_bc_before", bus.bit_count, 2);
    applyStimulus(1, 1, 1, 0);
    checkOutput("sync_bc_after", bus.bit_count, 1);
    checkOutput("sync_no_word", bus.valid, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("sync_parallel_out", bus.parallel_out, 4'b1111);
    checkOutput("sync_valid", bus.valid, 1);
    checkOutput("sync_reg_content", bus.reg_content, 4'b1111);
    applyStimulus(0, 0, 0, 1);
    checkOutput("sync_ack_valid", bus.valid, 0);

    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 1, 0);
    checkOutput("sync_last_no_word", bus.valid, 0);
    checkOutput("sync_last_hold_out", bus.parallel_out, 4'b1111);
    checkOutput("sync_last_bc", bus.bit_count, 1);
    checkOutput("sync_last_reg", bus.reg_content, 4'b0101);
    applyStimulus(0, 0, 1, 0);
    checkOutput("sync_idle_bc", bus.bit_count, 0);
    checkOutput("sync_idle_reg", bus.reg_content, 4'b0101);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/serial_in_parallel_out_framed_receiver.md
# serial_in_parallel_out_framed_receiver

Receives a serial bit stream and rebuilds it into parallel words; it is the receiving end of the team's parallel-in/serial-out shift link. Bits arrive MSB first, one per enabled clock. A bit counter frames each word, and a one-word output buffer with a Valid/Ack handshake holds the result. A sticky flag reports words lost to overrun.

## Interface
- WIDTH, 4, word width in bits (≥2)
- Clk  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- ShiftIn  input  1  serial data bit, MSB of each word first
- ShiftEn  input  1  ShiftIn is sampled on this edge
- Sync  input  1  frame restart; discards any partial word
- Ack  input  1  consumer accepts ParallelOut
- ParallelOut  output  WIDTH  last completed word
- Valid  output  1  ParallelOut holds an unacknowledged word
- Overrun  output  1  sticky; a completed word was dropped
- BitCount  output  $clog2(WIDTH)  bits received in the current frame
- RegContent  output  WIDTH  live shift register contents

## Operation
- Shift: when ShiftEn=1, the register loads {shift_reg[WIDTH-2:0], ShiftIn}. The first bit received ends up in the MSB.
- Bit counter: increments on each ShiftEn. When BitCount==WIDTH-1 and ShiftEn=1, the word is complete and BitCount wraps to 0.
- Sync with ShiftEn=1: the bit is shifted in as bit 0 of a new frame and BitCount becomes 1.
- Sync with ShiftEn=0: BitCount becomes 0.
- Sync never alters ParallelOut, Valid or Overrun.
- Sync on the cycle the counter would complete a word: Sync wins and no word completes.
- Output buffer FSM, state EMPTY (Valid=0) or FULL (Valid=1):
  - EMPTY, word completes: ParallelOut <= {shift_reg[WIDTH-2:0], ShiftIn}, go to FULL.
  - FULL, Ack=1, no completion: go to EMPTY. ParallelOut keeps its value.
  - FULL, Ack=1, completion in the same cycle: load the new word and stay FULL. No overrun.
  - FULL, Ack=0, completion: the new word is discarded, ParallelOut is held, and Overrun <= 1.
  - Ack while EMPTY is ignored.
- Overrun stays high until Reset.
- Reset: shift_reg, BitCount, ParallelOut, Valid and Overrun all go to 0 and the FSM goes to EMPTY. Reset overrides every other input, including during a partial frame.

## Timing
- All state updates happen on the rising edge of Clk. There is no combinational path from input to output.
- Word latency: Valid rises in the cycle after the edge that samples the final bit. It is therefore visible 1 cycle after the last ShiftEn.
- Valid falls in the cycle after the edge at which Ack=1 is sampled.
- Back-to-back words: with ShiftEn held high, a word completes every WIDTH cycles. Asserting Ack in the cycle Valid is seen gives zero loss.
- RegContent and BitCount update one cycle after the sampled input.

## Structure
- Shared package:
  - buffer-state typedef: enum {EMPTY, FULL}
  - a helper function for the counter width: $clog2(WIDTH)
- One sub-module, sipo_shift_core: the shift register plus bit counter, with Sync handling. It outputs a one-cycle word_done pulse and next_word.
- The top level holds the output buffer FSM and the Overrun flag.

## Test plan
All scenarios use WIDTH=4.
- Reset after random traffic: all outputs are 0 on the next cycle.
- Loopback: 1,0,1,1 shifted on 4 consecutive ShiftEn cycles gives ParallelOut=4'b1011 and Valid=1 one cycle after the 4th bit. Ack then gives Valid=0.
- Gapped input: bits 0,1,1,0 with ShiftEn idle between them give 4'b0110. BitCount reads 1,2,3,0 across the gaps.
- Overrun: send 4'b1100 without Ack, then 4'b0011 → ParallelOut stays 4'b1100 and Overrun=1. After Ack, Valid=0 and Overrun stays 1.
- Simultaneous Ack and completion: with 4'b1001 held Valid, Ack coincides with the last bit of 4'b0101 → ParallelOut=4'b0101, Valid stays 1, Overrun=0.
- Sync mid-frame: after 2 bits, Sync with ShiftEn=1 and bit 1, then 1,1,1 → ParallelOut=4'b1111 and BitCount=1 after the Sync edge. A Sync on the 4th-bit cycle produces no word.
